message_loader: RTL
===================

# message_loader

Upstream stage of the scrolling-message path: lets the user type a message into the 32-entry character RAM from the 5-bit switch code and three push buttons. It produces the RAM write strobe, address and data, and tracks the message length. After a commit it raises `run`, which enables the address counter and scroller downstream. On reset and on request it blanks the whole RAM.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width.
- `DATA_W`, 5, character code width.
- `DEPTH`, 32, RAM entries; equals 2**ADDR_W.
- `DEBOUNCE_CYCLES`, 500000, stable-level cycles required before a button press is accepted (10 ms at 50 MHz).
- `BLANK_CODE`, 5'h1F, code written during clear; the ROM maps it to all segments off.

Ports:
- `clock`, in, 1: single clock for the block.
- `Reset`, in, 1: synchronous, active-high.
- `data_in`, in, DATA_W: character code from the switches.
- `btn_store`, in, 1: raw and asynchronous; appends `data_in`.
- `btn_done`, in, 1: raw; toggles between LOAD and RUN.
- `btn_clear`, in, 1: raw; blanks the RAM and restarts entry.
- `we`, out, 1: RAM write enable. Registered; reset value 0.
- `address`, out, ADDR_W: RAM write address. Registered; reset value 0.
- `data_out`, out, DATA_W: RAM write data. Registered; reset value BLANK_CODE.
- `length`, out, ADDR_W+1: characters stored, 0..32. Reset value 0.
- `run`, out, 1: high only in RUN. Reset value 0.
- `full`, out, 1: high when `length` == DEPTH. Reset value 0.
- `busy`, out, 1: high only in CLEAR. Reset value 1.

## Operation
- Each raw button passes through `btn_debounce`, which produces a 1-cycle `*_p` pulse.
- Press priority within one cycle: clear_p > done_p > store_p. Lower-priority pulses in the same cycle are dropped.
- CLEAR:
  - Entered on Reset, or on clear_p from any state.
  - Writes BLANK_CODE to addresses 0..31 on 32 consecutive cycles.
  - Then goes to LOAD with wr_ptr = 0 and length = 0.
  - All pulses are ignored while in CLEAR.
- LOAD:
  - store_p with length < DEPTH: write `data_in` (sampled in the pulse cycle) to wr_ptr, then increment wr_ptr and length.
  - store_p with `full` set: ignored; no write.
  - done_p with length > 0: go to RUN.
  - done_p with length == 0: ignored.
- RUN:
  - `we` = 0; store_p is ignored.
  - done_p: go back to LOAD with content and wr_ptr kept, so entry appends.
- Arithmetic:
  - wr_ptr is ADDR_W bits and never wraps, because writes stop at `full`.
  - length saturates at DEPTH.

## Timing
- Reset sampled high at edge k:
  - After edge k: outputs hold their reset values; state = CLEAR with clear counter 0.
  - Edges k+1..k+32 present `we`=1 with `address` 0..31.
  - After edge k+33: `we`=0, `busy`=0, state = LOAD.
- Reset asserted in any state, including mid-CLEAR: CLEAR restarts from address 0 and length is zeroed.
- Debounce latency:
  - Raw edge to `*_p` = 2 synchroniser cycles + DEBOUNCE_CYCLES.
  - A bounce inside the window restarts the count.
  - Releasing and pressing again is required for a second pulse.
- store_p at cycle n:
  - `we`=1 with address/data valid in cycle n+1, for exactly 1 cycle.
  - `length` updates in cycle n+1.
- done_p at cycle n: `run` changes in cycle n+1.
- clear_p at cycle n: `busy`=1 and the first blank write occur in cycle n+1.

## Structure
- Package `msg_pkg` holds:
  - the state enum {CLEAR, LOAD, RUN};
  - the default BLANK_CODE, DEPTH, ADDR_W and DATA_W constants.
- Sub-module `btn_debounce`, instantiated three times:
  - 2-flop synchroniser;
  - stable counter of $clog2(DEBOUNCE_CYCLES+1) bits;
  - rising-edge pulse on the debounced level.
- Top level contains the FSM, wr_ptr, the clear counter and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then idle:
  - 32 writes of 5'h1F at addresses 0..31 on consecutive cycles.
  - `busy` falls after the last write; `length`=0; `run`=0.
- data_in=5'd3, store; data_in=5'd7, store:
  - writes (0,3) and (1,7), one cycle each;
  - `length`=2.
- Store pressed 33 times:
  - 32 writes; `full`=1 after the 32nd;
  - the 33rd press produces no `we`; `length` stays 32.
- Done pressed with length 0:
  - `run` stays 0.
- After 2 stores, done:
  - `run`=1; store is ignored.
  - Done again gives `run`=0; a further store writes address 2.
- Raw button glitch:
  - a 3-cycle high pulse produces no pulse and no write.
- Clear during RUN:
  - CLEAR restarts;
  - Reset asserted at clear address 10 restarts the sweep at address 0;
  - `length`=0 on exit.
- Clear and store pressed simultaneously:
  - only CLEAR occurs; no write of `data_in`.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and default sizes for the message entry path.
// The state enum is used by the loader FSM; the constants seed its parameters.
package msg_pkg;

    localparam int MSG_ADDR_W = 5;
    localparam int MSG_DATA_W = 5;
    localparam int MSG_DEPTH  = 32;
    localparam logic [MSG_DATA_W-1:0] MSG_BLANK_CODE = 5'h1F;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } msg_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: two-flop synchroniser, stable-level down-counter,
// and a single-cycle pulse when the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Any cycle where the synchronised input matches the accepted level
    // reloads the timer, so a bounce restarts the stability window.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= RELOAD;
            pulse   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            pulse  <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= RELOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync_q[1];
                cnt_q   <= RELOAD;
                pulse   <= sync_q[1];
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/message_loader.sv
// Message entry controller: fills the character RAM from the switches and buttons,
// blanks the RAM on reset or request, and raises run once a message is committed.
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | sweeping BLANK_CODE over every RAM address; buttons ignored
// LOAD  | user entry: store appends data_in, done commits to RUN
// RUN   | message committed; downstream scroller enabled
module message_loader
    import msg_pkg::*;
#(
    parameter int ADDR_W          = MSG_ADDR_W,
    parameter int DATA_W          = MSG_DATA_W,
    parameter int DEPTH           = MSG_DEPTH,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter logic [DATA_W-1:0] BLANK_CODE = MSG_BLANK_CODE
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              btn_store,
    input  logic              btn_done,
    input  logic              btn_clear,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   length,
    output logic              run,
    output logic              full,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    logic store_p;
    logic done_p;
    logic clear_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_store (
        .clock (clock),
        .reset (Reset),
        .btn   (btn_store),
        .pulse (store_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_done (
        .clock (clock),
        .reset (Reset),
        .btn   (btn_done),
        .pulse (done_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock (clock),
        .reset (Reset),
        .btn   (btn_clear),
        .pulse (clear_p)
    );

    msg_state_e        state_q,    state_n;
    logic [ADDR_W:0]   clr_cnt_q,  clr_cnt_n;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_n;
    logic [ADDR_W:0]   length_q,   length_n;
    logic              we_q,       we_n;
    logic [ADDR_W-1:0] address_q,  address_n;
    logic [DATA_W-1:0] data_q,     data_n;

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            length_q  <= '0;
            we_q      <= 1'b0;
            address_q <= '0;
            data_q    <= BLANK_CODE;
        end else begin
            state_q   <= state_n;
            clr_cnt_q <= clr_cnt_n;
            wr_ptr_q  <= wr_ptr_n;
            length_q  <= length_n;
            we_q      <= we_n;
            address_q <= address_n;
            data_q    <= data_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        clr_cnt_n = clr_cnt_q;
        wr_ptr_n  = wr_ptr_q;
        length_n  = length_q;
        we_n      = 1'b0;
        address_n = address_q;
        data_n    = data_q;

        unique case (state_q)
            CLEAR: begin
                // Counter runs one past the last address so busy covers the final write.
                if (clr_cnt_q < DEPTH_L) begin
                    we_n      = 1'b1;
                    address_n = clr_cnt_q[ADDR_W-1:0];
                    data_n    = BLANK_CODE;
                    clr_cnt_n = clr_cnt_q + 1'b1;
                end else begin
                    state_n  = LOAD;
                    wr_ptr_n = '0;
                    length_n = '0;
                end
            end

            LOAD: begin
                if (clear_p) begin
                    state_n   = CLEAR;
                    we_n      = 1'b1;
                    address_n = '0;
                    data_n    = BLANK_CODE;
                    clr_cnt_n = (ADDR_W + 1)'(1);
                    wr_ptr_n  = '0;
                    length_n  = '0;
                end else if (done_p) begin
                    if (length_q != '0) begin
                        state_n = RUN;
                    end
                end else if (store_p && (length_q < DEPTH_L)) begin
                    we_n      = 1'b1;
                    address_n = wr_ptr_q;
                    data_n    = data_in;
                    length_n  = length_q + 1'b1;
                    if (wr_ptr_q != ADDR_MAX) begin
                        wr_ptr_n = wr_ptr_q + 1'b1;
                    end
                end
            end

            RUN: begin
                if (clear_p) begin
                    state_n   = CLEAR;
                    we_n      = 1'b1;
                    address_n = '0;
                    data_n    = BLANK_CODE;
                    clr_cnt_n = (ADDR_W + 1)'(1);
                    wr_ptr_n  = '0;
                    length_n  = '0;
                end else if (done_p) begin
                    state_n = LOAD;
                end
            end

            default: begin
                state_n   = CLEAR;
                clr_cnt_n = '0;
            end
        endcase
    end

    assign we       = we_q;
    assign address  = address_q;
    assign data_out = data_q;
    assign length   = length_q;
    assign run      = (state_q == RUN);
    assign busy     = (state_q == CLEAR);
    assign full     = (length_q == DEPTH_L);

endmodule
